// File: rtl/id_ctrl_stage.sv
// ID-stage control decode registered into the ID/EX boundary, with load-use and
// multiplier hazard detection, bubble injection and a multiplier occupancy FSM.
module id_ctrl_stage #(
  parameter int MULT_LAT = 4,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        opin,
  input  logic [5:0]        funcin,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_isBranch,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic              ex_isj,
  output logic              ex_NotSht,
  output logic              ex_isMult,
  output logic              ex_isAcc,
  output logic [5:0]        ex_op,
  output logic [5:0]        ex_func,
  output logic              illegal,
  output logic              mult_busy
);

  typedef struct packed {
    logic is_branch;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic is_j;
    logic not_sht;
    logic is_mult;
    logic is_acc;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_BUSY} mstate_t;

  localparam logic [3:0] LAT_M1 = 4'(MULT_LAT - 1);

  ctrl_t       ctrl_d, ctrl_q;
  logic        illegal_d, illegal_q;
  logic        ex_valid_q;
  logic [5:0]  ex_op_q, ex_func_q;
  logic        load_use, mult_haz, issue;
  mstate_t     state_q, state_d;
  logic [3:0]  mult_cnt_q, mult_cnt_d;

  // Combinational decode; anything unrecognised decodes as nop and is flagged.
  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    case (opin)
      6'd0: begin
        case (funcin)
          6'd0: ;
          6'd2: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
          end
          6'd25: begin
            ctrl_d.alu_src = 1'b1;
            ctrl_d.is_mult = 1'b1;
            ctrl_d.not_sht = 1'b1;
          end
          default: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.not_sht   = 1'b1;
          end
        endcase
      end
      6'd2: begin
        ctrl_d.is_j    = 1'b1;
        ctrl_d.not_sht = 1'b1;
      end
      6'd4: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.is_branch = 1'b1;
        ctrl_d.not_sht   = 1'b1;
      end
      6'd9: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.not_sht   = 1'b1;
      end
      6'd35: begin
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.not_sht    = 1'b1;
      end
      6'd43: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.not_sht   = 1'b1;
      end
      6'd28: begin
        ctrl_d.alu_src = 1'b1;
        ctrl_d.is_mult = 1'b1;
        ctrl_d.is_acc  = 1'b1;
        ctrl_d.not_sht = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign load_use = ex_memread_i & ex_valid_q & id_valid & (ex_rt_i != '0) &
                    ((ex_rt_i == id_rs) | (ex_rt_i == id_rt));
  assign mult_haz = id_valid & ctrl_d.is_mult & (mult_cnt_q != 4'd0);
  assign stall    = (load_use | mult_haz) & ~flush & ~rst;
  assign issue    = id_valid & ~flush & ~stall;

  // ID/EX register: anything not issued becomes an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      ctrl_q     <= '0;
      illegal_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_func_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      illegal_q  <= illegal_d;
      ex_valid_q <= 1'b1;
      ex_op_q    <= opin;
      ex_func_q  <= funcin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mult_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
    end
  end

  // Busy countdown keeps running through stall and flush.
  always_comb begin
    state_d    = state_q;
    mult_cnt_d = mult_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue && ctrl_d.is_mult && (LAT_M1 != 4'd0)) begin
          state_d    = S_BUSY;
          mult_cnt_d = LAT_M1;
        end
      end
      S_BUSY: begin
        mult_cnt_d = mult_cnt_q - 4'd1;
        if (mult_cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        mult_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    mult_busy = (mult_cnt_q != 4'd0);
  end

  assign ex_valid    = ex_valid_q;
  assign illegal     = illegal_q;
  assign ex_op       = ex_op_q;
  assign ex_func     = ex_func_q;
  assign ex_isBranch = ctrl_q.is_branch;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_RegDst   = ctrl_q.reg_dst;
  assign ex_isj      = ctrl_q.is_j;
  assign ex_NotSht   = ctrl_q.not_sht;
  assign ex_isMult   = ctrl_q.is_mult;
  assign ex_isAcc    = ctrl_q.is_acc;

endmodule
